// File: rtl/aha_axi_to_sif_read_addr_if.sv
// AR channel, R-handshake credit return and SIF read-request bundle
// for the AXI-to-SIF read-address front end.
interface aha_axi_to_sif_read_addr_if #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 32
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic              RVALID;
  logic              RREADY;
  logic              SIF_RD_EN;
  logic [ADDR_W-1:0] SIF_RD_ADDR;
  logic [CNT_W-1:0]  OUTSTANDING;
  logic              ERR_UNDERFLOW;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RVALID, RREADY,
    input  ARREADY, SIF_RD_EN, SIF_RD_ADDR, OUTSTANDING, ERR_UNDERFLOW
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RVALID, RREADY,
    output ARREADY, SIF_RD_EN, SIF_RD_ADDR, OUTSTANDING, ERR_UNDERFLOW
  );
endinterface

// File: rtl/aha_axi_to_sif_read_addr.sv
// AXI4 read-address front end: expands one AR burst into per-beat SIF read
// requests, throttled by a credit counter sized to the downstream data FIFO.
module aha_axi_to_sif_read_addr #(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  aha_axi_to_sif_read_addr_if.slave     bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BURST} state_t;
  typedef enum logic [1:0] {BM_FIXED, BM_INCR, BM_WRAP} bmode_t;

  state_t            state_reg, state_next;
  bmode_t            mode_reg, mode_cap;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] wrap_mask_reg, wrap_mask_cap;
  logic [7:0]        beats_left_reg;
  logic [1:0]        size_reg, size_cap;
  logic [CNT_W-1:0]  out_reg;
  logic              err_reg;

  logic              arready;
  logic              issue;
  logic              ar_fire;
  logic              pop;
  logic              credit_ok;
  logic              wrap_len_ok;
  logic [ADDR_W-1:0] step;

  assign credit_ok = out_reg < CNT_W'(MAX_OUTSTANDING);
  assign ar_fire   = arready && bus.ARVALID;
  assign pop       = bus.RVALID && bus.RREADY;

  // Decode of the AR request at capture time
  assign size_cap    = (bus.ARSIZE > 3'd3) ? 2'd3 : bus.ARSIZE[1:0];
  assign wrap_len_ok = (bus.ARLEN == 8'd1) || (bus.ARLEN == 8'd3) ||
                       (bus.ARLEN == 8'd7) || (bus.ARLEN == 8'd15);
  assign wrap_mask_cap = ((ADDR_W'(bus.ARLEN) + ADDR_W'(1)) << size_cap) - ADDR_W'(1);

  always_comb begin
    mode_cap = BM_INCR;
    if (bus.ARBURST == 2'b00)
      mode_cap = BM_FIXED;
    else if (bus.ARBURST == 2'b10 && wrap_len_ok)
      mode_cap = BM_WRAP;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_reg <= ST_INIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    arready    = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      ST_INIT:  state_next = ST_IDLE;
      ST_IDLE: begin
        arready = 1'b1;
        if (bus.ARVALID) state_next = ST_BURST;
      end
      ST_BURST: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (beats_left_reg == 8'd0) state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_INIT;
    endcase
  end

  // Wrap keeps the upper (base) bits of the address and rolls the low bits
  assign step = ADDR_W'(1) << size_reg;

  always_comb begin
    addr_next = (addr_reg & ~(step - ADDR_W'(1))) + step;
    case (mode_reg)
      BM_FIXED: addr_next = addr_reg;
      BM_WRAP:  addr_next = (addr_reg & ~wrap_mask_reg) |
                            ((addr_reg + step) & wrap_mask_reg);
      default:  addr_next = (addr_reg & ~(step - ADDR_W'(1))) + step;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_reg       <= '0;
      wrap_mask_reg  <= '0;
      beats_left_reg <= '0;
      size_reg       <= '0;
      mode_reg       <= BM_INCR;
    end else if (ar_fire) begin
      addr_reg       <= bus.ARADDR;
      wrap_mask_reg  <= wrap_mask_cap;
      beats_left_reg <= bus.ARLEN;
      size_reg       <= size_cap;
      mode_reg       <= mode_cap;
    end else if (issue) begin
      addr_reg       <= addr_next;
      beats_left_reg <= beats_left_reg - 8'd1;
    end
  end

  // Credit counter: a simultaneous issue and pop cancel out
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case ({issue, pop})
        2'b10: out_reg <= out_reg + CNT_W'(1);
        2'b01: begin
          if (out_reg == '0) err_reg <= 1'b1;
          else               out_reg <= out_reg - CNT_W'(1);
        end
        default: out_reg <= out_reg;
      endcase
    end
  end

  assign bus.ARREADY       = arready;
  assign bus.SIF_RD_EN     = issue;
  assign bus.SIF_RD_ADDR   = addr_reg;
  assign bus.OUTSTANDING   = out_reg;
  assign bus.ERR_UNDERFLOW = err_reg;
endmodule

// File: tb/tb_aha_axi_to_sif_read_addr.sv
// Scoreboard bench: expected beat addresses are queued when an AR burst is
// driven and popped by a monitor whenever SIF_RD_EN is seen.
module tb_aha_axi_to_sif_read_addr;
  localparam int ADDR_W = 32;
  localparam int MAXO   = 32;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  aha_axi_to_sif_read_addr_if #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) bus ();

  aha_axi_to_sif_read_addr #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAXO)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge
  always @(negedge ACLK) begin
    if (!ARESET && bus.SIF_RD_EN === 1'b1) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        $display("beat %0d addr 0x%0h exp 0x%0h", beat_cnt, bus.SIF_RD_ADDR, e);
        chk("sb_addr", 64'(bus.SIF_RD_ADDR), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_pop();
    bus.RVALID = 1'b1;
    bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.RVALID = 1'b0;
    bus.RREADY = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    bus.ARVALID = 1'b0;
    bus.RVALID = 1'b0;
    bus.RREADY = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_arready", 64'(bus.ARREADY), 64'd0);
    chk("rst_sif_en", 64'(bus.SIF_RD_EN), 64'd0);
    chk("rst_sif_addr", 64'(bus.SIF_RD_ADDR), 64'd0);
    chk("rst_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    chk("rst_err", 64'(bus.ERR_UNDERFLOW), 64'd0);
    exp_q.delete();
    beat_cnt = 0;
    ARESET = 1'b0;
    #1;
    chk("init_arready", 64'(bus.ARREADY), 64'd0);
    @(posedge ACLK); #1;
    chk("post_rst_arready", 64'(bus.ARREADY), 64'd1);
  endtask

  // Returns at #1 after the handshake edge
  task automatic send_ar(input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n;
    n = 0;
    bus.ARADDR = a;
    bus.ARLEN = len;
    bus.ARSIZE = sz;
    bus.ARBURST = bt;
    bus.ARVALID = 1'b1;
    while (bus.ARREADY !== 1'b1 && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (bus.ARREADY !== 1'b1) chk("ar_timeout", 64'(bus.ARREADY), 64'd1);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
    $display("AR addr 0x%0h len %0d size %0d burst %0d", a, len, sz, bt);
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ARREADY !== 1'b1) && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push_incr(input logic [31:0] start, input int n, input int sz);
    logic [31:0] a;
    logic [31:0] st;
    a = start;
    st = 32'd1 << sz;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = (a & ~(st - 32'd1)) + st;
    end
  endtask

  initial begin
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARSIZE = '0;
    bus.ARBURST = '0;
    bus.ARVALID = 1'b0;
    bus.RVALID = 1'b0;
    bus.RREADY = 1'b0;
    do_reset();

    // INCR timing: four consecutive beats, then ARREADY
    exp_q.push_back(32'h100); exp_q.push_back(32'h108);
    exp_q.push_back(32'h110); exp_q.push_back(32'h118);
    send_ar(32'h100, 8'd3, 3'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      chk("incr_en_cycle", 64'(bus.SIF_RD_EN), 64'd1);
      chk("incr_arready_low", 64'(bus.ARREADY), 64'd0);
      @(posedge ACLK); #1;
    end
    chk("incr_arready_back", 64'(bus.ARREADY), 64'd1);
    chk("incr_en_done", 64'(bus.SIF_RD_EN), 64'd0);
    chk("incr_outstanding", 64'(bus.OUTSTANDING), 64'd4);
    wait_drained("incr_drained");

    do_reset();
    exp_q.push_back(32'h1010); exp_q.push_back(32'h1018);
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1008);
    send_ar(32'h1010, 8'd3, 3'd3, 2'b10);
    wait_drained("wrap4_drained");

    exp_q.push_back(32'h1010); exp_q.push_back(32'h1018); exp_q.push_back(32'h1020);
    send_ar(32'h1010, 8'd2, 3'd3, 2'b10);
    wait_drained("wrap3_drained");

    exp_q.push_back(32'h40); exp_q.push_back(32'h40); exp_q.push_back(32'h40);
    send_ar(32'h40, 8'd2, 3'd3, 2'b00);
    wait_drained("fixed_drained");

    exp_q.push_back(32'h103); exp_q.push_back(32'h104);
    send_ar(32'h103, 8'd1, 3'd2, 2'b01);
    wait_drained("unaligned_drained");
    chk("accum_outstanding", 64'(bus.OUTSTANDING), 64'd12);

    // Credit stall with RREADY low, then single pop, then continuous pops
    do_reset();
    push_incr(32'h2000, 40, 2);
    send_ar(32'h2000, 8'd39, 3'd2, 2'b01);
    repeat (40) @(posedge ACLK);
    #1;
    chk("stall_beats", 64'(beat_cnt), 64'd32);
    chk("stall_outstanding", 64'(bus.OUTSTANDING), 64'd32);
    chk("stall_en_low", 64'(bus.SIF_RD_EN), 64'd0);
    pulse_pop();
    repeat (3) @(posedge ACLK);
    #1;
    chk("one_credit_beats", 64'(beat_cnt), 64'd33);
    chk("one_credit_outstanding", 64'(bus.OUTSTANDING), 64'd32);
    bus.RVALID = 1'b1;
    bus.RREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (i < 7) chk("steady_outstanding", 64'(bus.OUTSTANDING), 64'd31);
    end
    bus.RVALID = 1'b0;
    bus.RREADY = 1'b0;
    chk("stream_beats", 64'(beat_cnt), 64'd40);
    chk("stream_outstanding", 64'(bus.OUTSTANDING), 64'd29);
    wait_drained("stream_drained");

    // Underflow is sticky
    do_reset();
    pulse_pop();
    chk("uflow_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    chk("uflow_err", 64'(bus.ERR_UNDERFLOW), 64'd1);
    repeat (5) @(posedge ACLK);
    #1;
    chk("uflow_err_sticky", 64'(bus.ERR_UNDERFLOW), 64'd1);

    // Reset mid-burst after the second beat
    do_reset();
    push_incr(32'h3000, 8, 3);
    send_ar(32'h3000, 8'd7, 3'd3, 2'b01);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    #1;
    chk("midrst_en", 64'(bus.SIF_RD_EN), 64'd0);
    chk("midrst_arready", 64'(bus.ARREADY), 64'd0);
    chk("midrst_addr", 64'(bus.SIF_RD_ADDR), 64'd0);
    chk("midrst_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    chk("midrst_remaining", 64'(exp_q.size()), 64'd6);
    do_reset();
    exp_q.push_back(32'h500);
    send_ar(32'h500, 8'd0, 3'd3, 2'b01);
    wait_drained("single_drained");
    repeat (3) @(posedge ACLK);
    #1;
    chk("single_beats", 64'(beat_cnt), 64'd1);
    chk("single_outstanding", 64'(bus.OUTSTANDING), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
